// File: rtl/sync_fifo_pkg.sv
// sync_fifo_flex shared definitions
// default geometry and pointer-width helper
package sync_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_flex storage array
// 1W/1R, synchronous write, asynchronous read, no reset
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
)(
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // store write data; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex top: pointers, flags, read port
// standard or first-word-fall-through read mode
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      wr_en,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [ptr_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW-1:0] DEP = PW'(DEPTH);
  localparam logic [PW-1:0] AF  = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE  = PW'(AE_THRESH);

  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_flex: WIDTH must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_flex: DEPTH must be a power of two >= 2");
  end
  if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thr
    $error("sync_fifo_flex: need AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] rdata;
  logic             wr_ok;
  logic             rd_ok;

  assign count        = wr_ptr - rd_ptr;
  assign full         = (count == DEP);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF);
  assign almost_empty = (count <= AE);

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // advance pointers on accepted operations
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ONE;
      if (rd_ok) rd_ptr <= rd_ptr + ONE;
    end
  end

  // flag rejected requests for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (din),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign dout = empty ? '0 : rdata;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;

    // capture head word on the edge that pops it
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        dout_q <= '0;
      else if (rd_ok) dout_q <= rdata;
    end

    assign dout = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// sync_fifo_flex directed bench
// standard-read instance plus FWFT instance
module tb_sync_fifo_flex;
  import sync_fifo_pkg::*;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int PW = ptr_w(D);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  din, din_f;
  logic          wr_en, rd_en, wr_f, rd_f;
  logic [W-1:0]  dout, dout_f;
  logic          full, empty, af, ae, ov, un;
  logic          full_f, empty_f, af_f, ae_f, ov_f, un_f;
  logic [PW-1:0] cnt, cnt_f;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sync_fifo_flex #(
    .WIDTH(W), .DEPTH(D), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .full(full), .empty(empty),
    .almost_full(af), .almost_empty(ae), .count(cnt),
    .overflow(ov), .underflow(un)
  );

  sync_fifo_flex #(
    .WIDTH(W), .DEPTH(D), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)
  ) u_fw (
    .clk(clk), .rst(rst), .din(din_f), .wr_en(wr_f), .rd_en(rd_f),
    .dout(dout_f), .full(full_f), .empty(empty_f),
    .almost_full(af_f), .almost_empty(ae_f), .count(cnt_f),
    .overflow(ov_f), .underflow(un_f)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    check({tag, "_cnt"}, 32'(cnt), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_ae"}, 32'(ae), 32'd1);
    check({tag, "_af"}, 32'(af), 32'd0);
    check({tag, "_ov"}, 32'(ov), 32'd0);
    check({tag, "_un"}, 32'(un), 32'd0);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_cnt_f"}, 32'(cnt_f), 32'd0);
    check({tag, "_empty_f"}, 32'(empty_f), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    din = '0; wr_en = 1'b0; rd_en = 1'b0;
    din_f = '0; wr_f = 1'b0; rd_f = 1'b0;
    #12;
    chk_rst("por");

    // fill; first write lands on first edge after rst falls
    wr_en = 1'b1;
    din = 8'h01;
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      din = 8'(i);
      tick();
      check("fill_cnt", 32'(cnt), 32'(i));
      check("fill_af", 32'(af), 32'(i >= 14));
      check("fill_ae", 32'(ae), 32'(i <= 2));
      check("fill_full", 32'(full), 32'(i == 16));
    end
    din = 8'h11;
    tick();
    check("ovf_pulse", 32'(ov), 32'd1);
    check("ovf_cnt", 32'(cnt), 32'd16);
    check("ovf_full", 32'(full), 32'd1);
    wr_en = 1'b0;
    tick();
    check("ovf_clear", 32'(ov), 32'd0);

    // drain in order
    rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("drain_dout", 32'(dout), 32'(i));
      check("drain_cnt", 32'(cnt), 32'(16 - i));
    end
    check("drain_empty", 32'(empty), 32'd1);
    tick();
    check("unf_pulse", 32'(un), 32'd1);
    check("unf_dout", 32'(dout), 32'h10);
    check("unf_cnt", 32'(cnt), 32'd0);
    rd_en = 1'b0;
    tick();
    check("unf_clear", 32'(un), 32'd0);

    // steady-state streaming across pointer wrap
    wr_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      din = 8'(8'h20 + k);
      tick();
    end
    rd_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      din = 8'(8'h28 + k);
      tick();
      check("wrap_dout", 32'(dout), 32'(8'h20 + k));
      check("wrap_cnt", 32'(cnt), 32'd8);
    end
    wr_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("wrap_tail", 32'(dout), 32'(8'h48 + k));
    end
    rd_en = 1'b0;
    check("wrap_empty", 32'(empty), 32'd1);

    // simultaneous request while full
    wr_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      din = 8'(8'h40 + k);
      tick();
    end
    rd_en = 1'b1;
    din = 8'hEE;
    tick();
    check("fullrw_ov", 32'(ov), 32'd1);
    check("fullrw_cnt", 32'(cnt), 32'd15);
    check("fullrw_dout", 32'(dout), 32'h40);
    check("fullrw_full", 32'(full), 32'd0);
    wr_en = 1'b0;
    for (int k = 1; k < 16; k++) begin
      tick();
      check("fullrw_drain", 32'(dout), 32'(8'h40 + k));
    end
    check("fullrw_empty", 32'(empty), 32'd1);

    // simultaneous request while empty
    wr_en = 1'b1;
    din = 8'h77;
    tick();
    check("emprw_un", 32'(un), 32'd1);
    check("emprw_cnt", 32'(cnt), 32'd1);
    check("emprw_dout", 32'(dout), 32'h4F);
    wr_en = 1'b0;
    tick();
    check("emprw_rd", 32'(dout), 32'h77);
    check("emprw_cnt0", 32'(cnt), 32'd0);
    check("emprw_unclr", 32'(un), 32'd0);
    rd_en = 1'b0;

    // asynchronous reset mid-burst
    wr_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      din = 8'(8'h60 + k);
      tick();
    end
    check("mid_cnt9", 32'(cnt), 32'd9);
    din = 8'h99;
    #3;
    rst = 1'b1;
    #1;
    chk_rst("arst");
    #2;
    rst = 1'b0;
    tick();
    check("post_cnt", 32'(cnt), 32'd1);
    check("post_ae", 32'(ae), 32'd1);
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    check("post_dout", 32'(dout), 32'h99);
    check("post_empty", 32'(empty), 32'd1);
    rd_en = 1'b0;

    // first-word-fall-through instance
    check("fw_rst_dout", 32'(dout_f), 32'd0);
    wr_f = 1'b1;
    din_f = 8'hA5;
    tick();
    check("fw_head", 32'(dout_f), 32'hA5);
    check("fw_nempty", 32'(empty_f), 32'd0);
    check("fw_cnt1", 32'(cnt_f), 32'd1);
    din_f = 8'h5A;
    tick();
    wr_f = 1'b0;
    check("fw_hold", 32'(dout_f), 32'hA5);
    check("fw_cnt2", 32'(cnt_f), 32'd2);
    rd_f = 1'b1;
    tick();
    check("fw_pop1", 32'(dout_f), 32'h5A);
    check("fw_cnt3", 32'(cnt_f), 32'd1);
    tick();
    check("fw_empty", 32'(empty_f), 32'd1);
    tick();
    check("fw_unf", 32'(un_f), 32'd1);
    rd_f = 1'b0;
    tick();
    check("fw_unf_clr", 32'(un_f), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised synchronous FIFO, the next generation of the team's 8-bit sync FIFO: configurable width and depth, programmable almost-full/almost-empty thresholds, occupancy count, overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode. It sits between a single-clock producer and consumer and is the DUT behind the existing FIFO verification interface, extended with the new outputs.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- din  in  WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read request
- dout  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write requested while full
- underflow  out  1  one-cycle pulse: read requested while empty

## Operation
- Write accepted iff wr_en && !full; din stored at wr_ptr, wr_ptr increments.
- Read accepted iff rd_en && !empty; rd_ptr increments.
- Pointers are $clog2(DEPTH)+1 bits; low bits address memory, MSB is wrap bit; natural binary wrap, no special case at DEPTH-1→0.
- count = wr_ptr − rd_ptr (modulo pointer width); full/empty/almost flags derive from registered pointers only, never from current-cycle wr_en/rd_en.
- Simultaneous wr_en && rd_en: both accepted if neither full nor empty, count unchanged. When full: read accepted, write rejected, overflow pulses. When empty: write accepted, read rejected, underflow pulses.
- Rejected operations change no state except the error pulse.
- FWFT=0: dout registered; updated with mem[rd_ptr] on the edge that accepts a read; holds otherwise.
- FWFT=1: dout = mem[rd_ptr] whenever !empty (head visible without rd_en); rd_en pops; dout is don't-care while empty.
- Reset (any time, including mid-burst): pointers 0, count 0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, dout=0. Memory contents not reset; data in flight is discarded.

## Timing
- Write at edge N → count/empty/almost flags reflect it in cycle N+1.
- FWFT=0: read accepted at edge N → dout valid in cycle N+1; minimum write-to-dout latency 2 edges.
- FWFT=1: write at edge N into empty FIFO → dout valid and empty=0 in cycle N+1; minimum write-to-dout latency 1 edge.
- overflow/underflow registered: asserted for exactly the cycle after the offending edge.
- Full-to-not-full: read at edge N → full=0 in cycle N+1; a write in cycle N is still rejected.
- Reset deassertion: first accepted operation on the first rising edge after rst falls.

## Structure
- Package sync_fifo_pkg: default WIDTH/DEPTH constants and a ptr_w function ($clog2(DEPTH)+1); shared by RTL and bench.
- Sub-module sync_fifo_ram: 1-write/1-read array, synchronous write, asynchronous read, no reset; top holds pointers, flags, dout register and error logic.
- Parameter checks (DEPTH power of two, AE_THRESH < AF_THRESH ≤ DEPTH) as elaboration-time assertions.

## Test plan
- Reset then 16 writes 0x01..0x10 (DEPTH=16) → almost_full at count 14, full after 16th, 17th write gives overflow pulse, count stays 16.
- Drain 16 reads (FWFT=0) → dout 0x01..0x10 in order, each one cycle after rd_en; 17th read → underflow pulse, dout holds 0x10.
- 8 entries, then wr_en && rd_en for 40 cycles → count stays 8, data order preserved across pointer wrap.
- Full FIFO, wr_en && rd_en same cycle → read accepted, write rejected, overflow=1, count 15; empty FIFO same stimulus → write accepted, underflow=1, count 1.
- FWFT=1: write 0xA5 to empty at edge N → dout=0xA5, empty=0 in cycle N+1 without rd_en.
- Assert rst asynchronously mid-burst with count 9 → immediately count=0, empty=1, flags/dout at reset values; next write/read sequence behaves as from power-up.
